// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, HLT opcode, bubble encoding and default widths.
package cpu_pkg;

   localparam int FETCH_ADDR_W  = 16;
   localparam int FETCH_INSTR_W = 16;

   localparam logic [3:0]  OPC_HLT   = 4'hF;
   localparam logic [15:0] NOP_INSTR = 16'h0000;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      HALT_PEND = 2'd1,
      HALTED    = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// Pipeline register between fetch and decode; flush beats load, otherwise it holds.
module if_id_reg
   import cpu_pkg::*;
#(
   parameter int                  ADDR_W    = FETCH_ADDR_W,
   parameter int                  INSTR_W   = FETCH_INSTR_W,
   parameter logic [INSTR_W-1:0]  BUBBLE    = cpu_pkg::NOP_INSTR
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_i,
   input  logic               flush_i,
   input  logic [INSTR_W-1:0] instr_i,
   input  logic [ADDR_W-1:0]  pc_plus1_i,
   output logic [INSTR_W-1:0] instr_o,
   output logic [ADDR_W-1:0]  pc_plus1_o,
   output logic               valid_o
);

   logic [INSTR_W-1:0] instr_q;
   logic [ADDR_W-1:0]  pc_plus1_q;
   logic               valid_q;

   // A bubble also clears the return address so stale PCs never leak into decode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q    <= BUBBLE;
         pc_plus1_q <= '0;
         valid_q    <= 1'b0;
      end else if (flush_i) begin
         instr_q    <= BUBBLE;
         pc_plus1_q <= '0;
         valid_q    <= 1'b0;
      end else if (load_i) begin
         instr_q    <= instr_i;
         pc_plus1_q <= pc_plus1_i;
         valid_q    <= 1'b1;
      end
   end

   assign instr_o    = instr_q;
   assign pc_plus1_o = pc_plus1_q;
   assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection, halt sequencing and the IF/ID register.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter int                 ADDR_W     = FETCH_ADDR_W,
   parameter int                 INSTR_W    = FETCH_INSTR_W,
   parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
   parameter logic [3:0]         HLT_OPCODE = OPC_HLT,
   parameter logic [INSTR_W-1:0] NOP_INSTR  = cpu_pkg::NOP_INSTR
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_target,
   input  logic               halt_retired,
   output logic [ADDR_W-1:0]  im_addr,
   output logic               im_rd_en,
   input  logic [INSTR_W-1:0] im_instr,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic [ADDR_W-1:0]  ifid_pc_plus1,
   output logic               ifid_valid,
   output logic [ADDR_W-1:0]  pc,
   output logic               hlt
);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              hlt_q;
   logic              ifid_load, ifid_flush;
   logic [ADDR_W-1:0] pc_inc;
   logic              is_hlt;

   assign pc_inc = pc_q + ADDR_W'(1);
   assign is_hlt = (im_instr[INSTR_W-1:INSTR_W-4] == HLT_OPCODE);

   // Edge priority: halt_retired (HALT_PEND only) > redirect > stall > advance.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ifid_load  = 1'b0;
      ifid_flush = 1'b0;
      unique case (state_q)
         RUN: begin
            if (redirect) begin
               pc_d       = redirect_target;
               ifid_flush = 1'b1;
            end else if (!stall) begin
               ifid_load = 1'b1;
               if (is_hlt) begin
                  state_d = HALT_PEND;
               end else begin
                  pc_d = pc_inc;
               end
            end
         end
         HALT_PEND: begin
            if (halt_retired) begin
               state_d    = HALTED;
               ifid_flush = 1'b1;
            end else if (redirect) begin
               state_d    = RUN;
               pc_d       = redirect_target;
               ifid_flush = 1'b1;
            end else if (!stall) begin
               ifid_flush = 1'b1;
            end
         end
         HALTED: begin
            ifid_flush = 1'b1;
         end
         default: begin
            state_d    = RUN;
            ifid_flush = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         hlt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         hlt_q   <= (state_d == HALTED);
      end
   end

   if_id_reg #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W),
      .BUBBLE  (NOP_INSTR)
   ) u_if_id (
      .clk        (clk),
      .rst        (rst),
      .load_i     (ifid_load),
      .flush_i    (ifid_flush),
      .instr_i    (im_instr),
      .pc_plus1_i (pc_inc),
      .instr_o    (ifid_instr),
      .pc_plus1_o (ifid_pc_plus1),
      .valid_o    (ifid_valid)
   );

   assign im_addr  = pc_q;
   assign im_rd_en = (state_q == RUN) && !stall;
   assign pc       = pc_q;
   assign hlt      = hlt_q;

   // Writeback must never retire a HLT that fetch has not seen.
   property p_no_retire_in_run;
      @(posedge clk) disable iff (rst) !((state_q == RUN) && halt_retired);
   endproperty
   a_no_retire_in_run: assert property (p_no_retire_in_run);

endmodule
